// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: FSM encoding,
// register word offsets, CTRL bit layout and MODE values.
package timer_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StCnt  = 2'd2,
        StInt  = 2'd3
    } timer_state_e;

    // Word offsets within the device window (PrAddr[3:2])
    localparam logic [1:0] AddrCtrl   = 2'd0;
    localparam logic [1:0] AddrPreset = 2'd1;
    localparam logic [1:0] AddrCount  = 2'd2;

    localparam int unsigned CtrlWidth   = 4;
    localparam int unsigned CtrlEnBit   = 0;
    localparam int unsigned CtrlModeLsb = 1;
    localparam int unsigned CtrlModeMsb = 2;
    localparam int unsigned CtrlImBit   = 3;

    localparam logic [1:0] ModeOneshot = 2'b00;
    localparam logic [1:0] ModeReload  = 2'b01;

    // Reserved modes 10/11 behave as one-shot, so only an exact 01 reloads.
    function automatic logic is_reload(input logic [1:0] mode);
        return (mode == ModeReload) && (mode != ModeOneshot);
    endfunction

endpackage

// File: rtl/timer_device.sv
// Countdown timer on the system bridge: CTRL/PRESET/COUNT register file plus a
// four-state load/count/interrupt FSM; irq feeds HWInt[0].
module timer_device
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       addr,
    input  logic             we,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] rd,
    output logic             irq
);

    timer_state_e state_q, state_d;

    logic [CtrlWidth-1:0] ctrl_q, ctrl_d;
    logic [WIDTH-1:0]     preset_q, preset_d;
    logic [WIDTH-1:0]     count_q, count_d;
    logic                 int_flag_q, int_flag_d;

    logic       wr_ctrl;
    logic       wr_preset;
    logic       fsm_set_flag;
    logic       fsm_clr_flag;
    logic       fsm_clr_en;
    logic       ctrl_en;
    logic [1:0] ctrl_mode;

    assign wr_ctrl   = we && (addr == AddrCtrl);
    assign wr_preset = we && (addr == AddrPreset);
    assign ctrl_en   = ctrl_q[CtrlEnBit];
    assign ctrl_mode = ctrl_q[CtrlModeMsb:CtrlModeLsb];

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        fsm_set_flag = 1'b0;
        fsm_clr_flag = 1'b0;
        fsm_clr_en   = 1'b0;
        case (state_q)
            StIdle: begin
                if (ctrl_en) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                count_d = preset_q;
                state_d = StCnt;
            end
            StCnt: begin
                if (!ctrl_en) begin
                    state_d = StIdle;
                end else if (count_q <= WIDTH'(1)) begin
                    // Stop at 1 so the decrement can never wrap below zero
                    count_d      = '0;
                    fsm_set_flag = 1'b1;
                    state_d      = StInt;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
            StInt: begin
                if (is_reload(ctrl_mode)) begin
                    fsm_clr_flag = 1'b1;
                    state_d      = StLoad;
                end else begin
                    fsm_clr_en = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        ctrl_d = ctrl_q;
        if (fsm_clr_en) begin
            ctrl_d[CtrlEnBit] = 1'b0;
        end
        // A CPU write to CTRL overrides the FSM's EN clear on the same edge
        if (wr_ctrl) begin
            ctrl_d = wd[CtrlWidth-1:0];
        end

        preset_d = wr_preset ? wd : preset_q;

        int_flag_d = int_flag_q;
        if (wr_ctrl || wr_preset || fsm_clr_flag) begin
            int_flag_d = 1'b0;
        end
        // Setting wins so an expiry coinciding with a CPU write is not lost
        if (fsm_set_flag) begin
            int_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            int_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            int_flag_q <= int_flag_d;
        end
    end

    always_comb begin
        rd = '0;
        case (addr)
            AddrCtrl:   rd = {{(WIDTH - CtrlWidth){1'b0}}, ctrl_q};
            AddrPreset: rd = preset_q;
            AddrCount:  rd = count_q;
            default:    rd = '0;
        endcase
    end

    assign irq = int_flag_q & ctrl_q[CtrlImBit];

endmodule

// File: doc/timer_device.md
Name: timer_device

Overview:
- Memory-mapped countdown timer on the system bridge, directly downstream of the CPU's PrAddr/PrWD/PrWe port.
- The bridge decodes the device window and drives addr/we/wd into this block.
- The block returns rd through the bridge into data_from_bridge.
- Its irq output drives one HWInt bit (HWInt[0]) of the CPU.

Parameters:
- WIDTH, 32: data/register width; matches PrWD.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (reset=0 clears all state immediately, independent of clk).
- addr  input  2  word select within device, taken from PrAddr[3:2]: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
- we  input  1  write enable; the bridge drives PrWe AND device-hit.
- wd  input  WIDTH  write data (PrWD).
- rd  output  WIDTH  read data, combinational from addr and registers.
- irq  output  1  interrupt request to HWInt.

Behaviour:
- Registers:
  - CTRL[3:0]: [0] EN, [2:1] MODE, [3] IM. Bits [31:4] read as 0.
  - PRESET[31:0]: read/write.
  - COUNT[31:0]: read-only; writes are ignored.
  - addr 3: reads 0; writes ignored.
- Reset values: CTRL=0, PRESET=0, COUNT=0, state=IDLE, int_flag=0, so irq=0 and rd reflects zeros.
- CPU writes: on a clock edge with we=1, the selected register is updated. A CPU write to CTRL in the same edge as an FSM-initiated EN clear wins.
- irq = int_flag AND CTRL.IM. This is combinational from registers, so no extra latency.
- FSM states, all transitions on clock edges:
  - IDLE: if EN=1, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT, EN=0: go to IDLE; COUNT holds.
  - CNT, EN=1 and COUNT<=1: COUNT <= 0, int_flag <= 1, go to INT.
  - CNT, EN=1, otherwise: COUNT <= COUNT-1.
  - INT, MODE=01 (auto-reload): int_flag <= 0, go to LOAD.
  - INT, MODE=00/10/11 (one-shot; 10/11 reserved and treated as 00): EN <= 0, go to IDLE; int_flag held.
- One-shot int_flag is cleared by any CPU write to CTRL or PRESET. If that write lands on the same edge that sets int_flag, the set wins, so no event is lost.
- Latency: EN written at edge E0 → LOAD after E1 → COUNT=N after E2 → COUNT reaches 0 and irq rises after edge E2+N (N>=1). N=0 behaves like N=1, entering INT after E3.
- Auto-reload period: N+2 cycles between irq pulses. Each pulse is exactly 1 cycle wide.
- Writing PRESET during CNT does not disturb COUNT; the new value loads at the next LOAD.
- Clearing EN during CNT freezes COUNT. Re-setting EN restarts via LOAD with a full reload; there is no resume.
- Clearing EN during INT: a one-shot still goes to IDLE; auto-reload goes to LOAD and then to IDLE at the next CNT.
- Decrement is modulo 2^WIDTH but never underflows, because of the COUNT<=1 check.
- Reset asserted mid-count: all state returns to reset values immediately; irq drops asynchronously.

Decomposition:
- Shared package timer_pkg holds:
  - FSM state encoding (IDLE, LOAD, CNT, INT; 2 bits).
  - Register word offsets (CTRL=0, PRESET=1, COUNT=2).
  - CTRL bit positions.
  - MODE constants (ONESHOT=2'b00, RELOAD=2'b01).
- No sub-module; a single flat module with a register file and FSM is natural. The bridge instantiates it.

Test Plan:
- Reset: hold reset=0 mid-count with COUNT=5 → COUNT=0, irq=0 immediately; CTRL reads 0 after release.
- One-shot: write PRESET=3, then CTRL=4'b1001 (IM, EN, mode 0) → COUNT reads 3,2,1,0; irq=1 from edge E5 and stays high; CTRL.EN reads 0; writing CTRL=0 drops irq next cycle.
- Auto-reload: PRESET=2, CTRL=4'b1011 → irq pulses 1 cycle wide, every 4 cycles, for at least 3 periods.
- Masked: PRESET=1, CTRL=4'b0001 → irq stays 0, but the flag is internally set; a later CTRL write with IM=1 and EN=0 clears it, so irq stays 0.
- Pause: during CNT at COUNT=7, write EN=0 → COUNT frozen at 6 for 10 cycles; set EN=1 → reload from PRESET.
- Boundary: PRESET=0 one-shot → INT after E3; a COUNT write is ignored; an addr=3 read returns 0; a PRESET write on the INT-entry edge leaves irq=1.
